// File: rtl/pkt_proc_ingress_pkg.sv
// -----------------------------------------------------------------------------
// pkt_proc_ingress_pkg
// Shared types and constants for the packet-processor ingress framer.
//   ingress_state_e : framer FSM states
//   LEN_W / DATA_W  : payload length field and data word widths
//   LVL_W / CNT_W   : processor fill-level width and statistics counter width
//   HDR_LEN_*       : position of the payload length inside the header word
// -----------------------------------------------------------------------------
package pkt_proc_ingress_pkg;

    localparam int LEN_W  = 12;
    localparam int DATA_W = 32;
    localparam int LVL_W  = 15;
    localparam int CNT_W  = 16;

    localparam int HDR_LEN_LSB = 0;
    localparam int HDR_LEN_MSB = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CHECK   = 2'd1,
        STREAM  = 2'd2,
        DISCARD = 2'd3
    } ingress_state_e;

    // Extract the declared payload length (in words) from a header word.
    function automatic logic [LEN_W-1:0] hdr_len(input logic [DATA_W-1:0] hdr);
        return hdr[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage

// File: rtl/pkt_proc_ingress_framer_if.sv
// -----------------------------------------------------------------------------
// pkt_proc_ingress_framer_if
// Line-side source stream into the ingress framer (valid/ready handshake).
//   s_valid : source word valid          (master -> slave)
//   s_data  : source word, header first  (master -> slave)
//   s_last  : last word of the packet    (master -> slave)
//   s_ready : framer accepts the word    (slave -> master)
// -----------------------------------------------------------------------------
interface pkt_proc_ingress_framer_if;
    import pkt_proc_ingress_pkg::*;

    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_last;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        output s_ready
    );

endinterface

// File: rtl/pkt_proc_sat_cnt.sv
// -----------------------------------------------------------------------------
// pkt_proc_sat_cnt
// Saturating event counter: counts cycles with inc=1, sticks at all-ones,
// cleared only by reset.
//   pck_proc_int_mem_fsm_clk : clock
//   pck_proc_int_mem_fsm_rst : synchronous active-high reset
//   inc                      : increment enable
//   cnt                      : counter value
// -----------------------------------------------------------------------------
module pkt_proc_sat_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             pck_proc_int_mem_fsm_clk,
    input  logic             pck_proc_int_mem_fsm_rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
        if (pck_proc_int_mem_fsm_rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= sat_inc(cnt);
        end
    end

endmodule

// File: rtl/pkt_proc_ingress_framer.sv
// -----------------------------------------------------------------------------
// pkt_proc_ingress_framer
// Ingress stage in front of the packet processor. Takes a header-prefixed
// word stream, strips the header, waits until the declared length fits in the
// processor memory and then streams the payload into the enqueue port.
// Malformed packets are consumed and discarded, and counted.
//
// Ports
//   pck_proc_int_mem_fsm_clk : clock (all logic on posedge)
//   pck_proc_int_mem_fsm_rst : synchronous active-high reset
//   src                      : source stream (slave modport)
//   pck_proc_wr_lvl          : processor memory fill level in words
//   pck_proc_full            : processor full, stalls the source
//   enq_req/in_sop/in_eop    : registered enqueue strobes
//   wr_data_i                : registered enqueue data
//   pck_len_valid/pck_len_i  : packet length, valid in the in_sop cycle
//   ingress_pkt_cnt          : packets enqueued (incl. length errors)
//   ingress_drop_cnt         : headers dropped without any enqueue
//   ingress_err_cnt          : enqueued packets whose length mismatched
// -----------------------------------------------------------------------------
module pkt_proc_ingress_framer
    import pkt_proc_ingress_pkg::*;
#(
    parameter int FIFO_DEPTH = 16384,
    parameter int MAX_LEN    = 4095,
    parameter int SETTLE     = 2
) (
    input  logic                     pck_proc_int_mem_fsm_clk,
    input  logic                     pck_proc_int_mem_fsm_rst,
    pkt_proc_ingress_framer_if.slave src,
    input  logic [LVL_W-1:0]         pck_proc_wr_lvl,
    input  logic                     pck_proc_full,
    output logic                     enq_req,
    output logic                     in_sop,
    output logic                     in_eop,
    output logic [DATA_W-1:0]        wr_data_i,
    output logic                     pck_len_valid,
    output logic [LEN_W-1:0]         pck_len_i,
    output logic [CNT_W-1:0]         ingress_pkt_cnt,
    output logic [CNT_W-1:0]         ingress_drop_cnt,
    output logic [CNT_W-1:0]         ingress_err_cnt
);

    localparam logic [LEN_W:0] MAX_LEN_C  = (LEN_W+1)'(MAX_LEN);
    localparam logic [15:0]    DEPTH_C    = 16'(FIFO_DEPTH);
    localparam int             SETTLE_SAT = (SETTLE > 255) ? 255 : SETTLE;
    localparam logic [7:0]     SETTLE_C   = 8'(SETTLE_SAT);

    ingress_state_e   state_q, state_nxt;

    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q, cnt_nxt;
    logic [7:0]       idle_cnt_q;

    logic             s_ready_c;
    logic             len_ld;
    logic             idle_clr;
    logic             enq_nxt, sop_nxt, eop_nxt;
    logic             pkt_inc, drop_inc, err_inc;

    logic [LEN_W-1:0] hdr_len_c;
    logic             hdr_bad;
    logic [15:0]      lvl_sum;
    logic             fits;
    logic             settled;
    logic             last_word;

    assign hdr_len_c = hdr_len(src.s_data);
    assign hdr_bad   = (hdr_len_c == '0) || ({1'b0, hdr_len_c} > MAX_LEN_C);

    // 15-bit level plus 12-bit length cannot overflow 16 bits.
    assign lvl_sum   = 16'(pck_proc_wr_lvl) + 16'(len_q);
    assign fits      = (lvl_sum <= DEPTH_C);
    assign settled   = (idle_cnt_q >= SETTLE_C);
    assign last_word = (cnt_q == len_q);

    assign src.s_ready = s_ready_c;

    // ---- FSM state register ----
    always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
        if (pck_proc_int_mem_fsm_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // ---- FSM next state and per-word decisions ----
    always_comb begin
        state_nxt = state_q;
        s_ready_c = 1'b0;
        len_ld    = 1'b0;
        idle_clr  = 1'b0;
        cnt_nxt   = cnt_q;
        enq_nxt   = 1'b0;
        sop_nxt   = 1'b0;
        eop_nxt   = 1'b0;
        pkt_inc   = 1'b0;
        drop_inc  = 1'b0;
        err_inc   = 1'b0;

        unique case (state_q)
            IDLE: begin
                s_ready_c = 1'b1;
                if (src.s_valid) begin
                    // The settle window restarts at every header so the
                    // level compare never uses a stale pck_proc_wr_lvl.
                    idle_clr = 1'b1;
                    if (src.s_last) begin
                        // Header-only packet: dropped on the spot, nothing
                        // left to drain.
                        drop_inc = 1'b1;
                    end else if (hdr_bad) begin
                        drop_inc  = 1'b1;
                        state_nxt = DISCARD;
                    end else begin
                        len_ld    = 1'b1;
                        state_nxt = CHECK;
                    end
                end
            end

            CHECK: begin
                // No timeout: the processor drains eventually.
                if (settled && fits) begin
                    cnt_nxt   = LEN_W'(1);
                    state_nxt = STREAM;
                end
            end

            STREAM: begin
                s_ready_c = ~pck_proc_full;
                if (src.s_valid && !pck_proc_full) begin
                    enq_nxt = 1'b1;
                    sop_nxt = (cnt_q == LEN_W'(1));
                    eop_nxt = last_word || src.s_last;
                    cnt_nxt = cnt_q + LEN_W'(1);
                    if (last_word) begin
                        pkt_inc = 1'b1;
                        if (src.s_last) begin
                            state_nxt = IDLE;
                        end else begin
                            // Long packet: close it here, drain the surplus.
                            err_inc   = 1'b1;
                            state_nxt = DISCARD;
                        end
                    end else if (src.s_last) begin
                        // Short packet: closed early, no padding.
                        pkt_inc   = 1'b1;
                        err_inc   = 1'b1;
                        state_nxt = IDLE;
                    end
                end
            end

            DISCARD: begin
                s_ready_c = 1'b1;
                if (src.s_valid && src.s_last) begin
                    state_nxt = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---- Packet context: latched length, word counter, settle counter ----
    always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
        if (pck_proc_int_mem_fsm_rst) begin
            len_q      <= '0;
            cnt_q      <= '0;
            idle_cnt_q <= '0;
        end else begin
            if (len_ld) begin
                len_q <= hdr_len_c;
            end
            cnt_q <= cnt_nxt;
            if (enq_req || idle_clr) begin
                idle_cnt_q <= '0;
            end else if (idle_cnt_q < SETTLE_C) begin
                idle_cnt_q <= idle_cnt_q + 8'd1;
            end
        end
    end

    // ---- Enqueue output register ----
    always_ff @(posedge pck_proc_int_mem_fsm_clk) begin
        if (pck_proc_int_mem_fsm_rst) begin
            enq_req       <= 1'b0;
            in_sop        <= 1'b0;
            in_eop        <= 1'b0;
            pck_len_valid <= 1'b0;
            pck_len_i     <= '0;
            wr_data_i     <= '0;
        end else begin
            enq_req       <= enq_nxt;
            in_sop        <= sop_nxt;
            in_eop        <= eop_nxt;
            pck_len_valid <= sop_nxt;
            if (sop_nxt) begin
                pck_len_i <= len_q;
            end
            if (enq_nxt) begin
                wr_data_i <= src.s_data;
            end
        end
    end

    // ---- Statistics ----
    pkt_proc_sat_cnt #(.CNT_W(CNT_W)) u_pkt_cnt (
        .pck_proc_int_mem_fsm_clk (pck_proc_int_mem_fsm_clk),
        .pck_proc_int_mem_fsm_rst (pck_proc_int_mem_fsm_rst),
        .inc                      (pkt_inc),
        .cnt                      (ingress_pkt_cnt)
    );

    pkt_proc_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
        .pck_proc_int_mem_fsm_clk (pck_proc_int_mem_fsm_clk),
        .pck_proc_int_mem_fsm_rst (pck_proc_int_mem_fsm_rst),
        .inc                      (drop_inc),
        .cnt                      (ingress_drop_cnt)
    );

    pkt_proc_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
        .pck_proc_int_mem_fsm_clk (pck_proc_int_mem_fsm_clk),
        .pck_proc_int_mem_fsm_rst (pck_proc_int_mem_fsm_rst),
        .inc                      (err_inc),
        .cnt                      (ingress_err_cnt)
    );

endmodule

// File: tb/tb_pkt_proc_ingress_framer.sv
// -----------------------------------------------------------------------------
// tb_pkt_proc_ingress_framer
// Self-checking bench: table of packet shapes, hand-written sequences for the
// level hold and full/reset corners, then randomized packets checked against a
// packet-level reference model.
// -----------------------------------------------------------------------------
module tb_pkt_proc_ingress_framer;

    // MAX_LEN below the 12-bit field range so that a header of 5000
    // (length field 904) is out of range.
    localparam int MAX_LEN    = 900;
    localparam int SETTLE     = 2;
    localparam int FIFO_DEPTH = 16384;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [14:0] wr_lvl = '0;
    logic        full = 1'b0;
    logic        enq_req, in_sop, in_eop, pck_len_valid;
    logic [31:0] wr_data_i;
    logic [11:0] pck_len_i;
    logic [15:0] pkt_cnt, drop_cnt, err_cnt;

    always #5 clk = ~clk;

    pkt_proc_ingress_framer_if src_if ();

    pkt_proc_ingress_framer #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .MAX_LEN    (MAX_LEN),
        .SETTLE     (SETTLE)
    ) dut (
        .pck_proc_int_mem_fsm_clk (clk),
        .pck_proc_int_mem_fsm_rst (rst),
        .src                      (src_if),
        .pck_proc_wr_lvl          (wr_lvl),
        .pck_proc_full            (full),
        .enq_req                  (enq_req),
        .in_sop                   (in_sop),
        .in_eop                   (in_eop),
        .wr_data_i                (wr_data_i),
        .pck_len_valid            (pck_len_valid),
        .pck_len_i                (pck_len_i),
        .ingress_pkt_cnt          (pkt_cnt),
        .ingress_drop_cnt         (drop_cnt),
        .ingress_err_cnt          (err_cnt)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic        lv;
        logic [11:0] len;
    } rec_t;

    typedef struct {
        logic [31:0] hdr;
        bit          hdr_last;
        int          npay;
        logic [14:0] lvl;
        int          exp_enq;
        int          exp_pkt;
        int          exp_err;
        int          exp_drop;
    } vec_t;

    rec_t        got[$];
    rec_t        exp_q[$];
    logic [31:0] pay[$];
    int          checks = 0;
    int          errors = 0;
    int          viol   = 0;
    int          m_pkt, m_drop, m_err;
    bit          abort    = 1'b0;
    bit          rnd_full = 1'b0;
    logic        full_q   = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, want);
        end
    endtask

    // Packet-level reference: what the processor should receive for one
    // source packet (header + pay[]), and how the counters move.
    task automatic model_pkt(input logic [31:0] hdr, input bit hdr_last);
        int len, n;
        len = int'(hdr[11:0]);
        if (hdr_last || len == 0 || len > MAX_LEN) begin
            m_drop++;
            return;
        end
        n = (pay.size() < len) ? pay.size() : len;
        for (int i = 0; i < n; i++)
            exp_q.push_back('{pay[i], (i == 0), (i == n - 1), (i == 0), 12'(len)});
        m_pkt++;
        if (pay.size() != len) m_err++;
    endtask

    task automatic cmp_recs(input string tag);
        int n;
        chk($sformatf("%s_nenq", tag), 64'(got.size()), 64'(exp_q.size()));
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_word%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
        got.delete();
        exp_q.delete();
    endtask

    task automatic chk_cnts(input string tag, input int p, input int d, input int e);
        chk($sformatf("%s_pkt_cnt", tag), 64'(pkt_cnt), 64'(p));
        chk($sformatf("%s_drop_cnt", tag), 64'(drop_cnt), 64'(d));
        chk($sformatf("%s_err_cnt", tag), 64'(err_cnt), 64'(e));
    endtask

    // Drives header then pay[]; s_last on the final word. Call aligned to
    // posedge+1; returns aligned to posedge+1 after the last accept.
    task automatic send_pkt(input logic [31:0] hdr, input bit hdr_last, input int gap);
        int nw, t;
        bit done;
        nw = pay.size() + 1;
        for (int i = 0; i < nw && !abort; i++) begin
            while (gap != 0 && $urandom_range(99) < gap) begin
                src_if.s_valid = 1'b0;
                @(posedge clk); #1;
            end
            src_if.s_valid = 1'b1;
            src_if.s_data  = (i == 0) ? hdr : pay[i-1];
            src_if.s_last  = (i == 0) ? hdr_last : (i == nw - 1);
            done = 1'b0;
            t    = 0;
            while (!done && !abort) begin
                @(negedge clk);
                if (src_if.s_ready) done = 1'b1;
                @(posedge clk); #1;
                t++;
                if (!done && t > 3000) begin
                    checks++;
                    errors++;
                    $display("FAIL handshake_timeout: word %0d not accepted after %0d cycles", i, t);
                    src_if.s_valid = 1'b0;
                    src_if.s_last  = 1'b0;
                    return;
                end
            end
        end
        src_if.s_valid = 1'b0;
        src_if.s_last  = 1'b0;
    endtask

    always @(posedge clk) full_q <= full;

    always @(posedge clk) begin
        if (rnd_full) begin
            #1;
            full = ($urandom_range(99) < 20);
        end
    end

    // Enqueue monitor; also flags an enqueue from an edge where full was high.
    always @(negedge clk) begin
        if (!rst) begin
            if (enq_req) got.push_back('{wr_data_i, in_sop, in_eop, pck_len_valid, pck_len_i});
            if (enq_req && full_q) viol++;
        end
    end

    vec_t vecs[10];

    initial begin
        int t_pkt, t_drop, t_err, k, len, npay;
        bit ok, hl;
        logic [31:0] hdr;

        vecs[0] = '{32'd3,         1'b0, 3,   15'd0,     3,   1, 0, 0};
        vecs[1] = '{32'd0,         1'b0, 2,   15'd0,     0,   0, 0, 1};
        vecs[2] = '{32'd5000,      1'b0, 2,   15'd0,     0,   0, 0, 1};
        vecs[3] = '{32'd4,         1'b0, 2,   15'd0,     2,   1, 1, 0};
        vecs[4] = '{32'd2,         1'b0, 4,   15'd0,     2,   1, 1, 0};
        vecs[5] = '{32'd1,         1'b0, 1,   15'd0,     1,   1, 0, 0};
        vecs[6] = '{32'd7,         1'b1, 0,   15'd0,     0,   0, 0, 1};
        vecs[7] = '{32'hABCD_E006, 1'b0, 6,   15'd16378, 6,   1, 0, 0};
        vecs[8] = '{32'd901,       1'b0, 1,   15'd0,     0,   0, 0, 1};
        vecs[9] = '{32'd900,       1'b0, 900, 15'd0,     900, 1, 0, 0};

        src_if.s_valid = 1'b0;
        src_if.s_data  = '0;
        src_if.s_last  = 1'b0;

        // ---- reset state ----
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst0_strobes", 64'({enq_req, in_sop, in_eop, pck_len_valid}), 64'(0));
        chk("rst0_data", 64'({wr_data_i, pck_len_i}), 64'(0));
        chk_cnts("rst0", 0, 0, 0);
        chk("rst0_s_ready", 64'(src_if.s_ready), 64'(1));

        // ---- table-driven packet shapes ----
        t_pkt = 0; t_drop = 0; t_err = 0;
        m_pkt = 0; m_drop = 0; m_err = 0;
        for (int v = 0; v < 10; v++) begin
            pay.delete();
            for (int i = 0; i < vecs[v].npay; i++) pay.push_back($urandom());
            wr_lvl = vecs[v].lvl;
            model_pkt(vecs[v].hdr, vecs[v].hdr_last);
            t_pkt  += vecs[v].exp_pkt;
            t_drop += vecs[v].exp_drop;
            t_err  += vecs[v].exp_err;
            @(posedge clk); #1;
            send_pkt(vecs[v].hdr, vecs[v].hdr_last, 0);
            repeat (2) @(negedge clk);
            chk($sformatf("v%0d_enq_count", v), 64'(got.size()), 64'(vecs[v].exp_enq));
            cmp_recs($sformatf("v%0d", v));
            chk_cnts($sformatf("v%0d", v), t_pkt, t_drop, t_err);
        end
        wr_lvl = '0;

        // ---- level hold in CHECK, then release ----
        pay.delete();
        for (int i = 0; i < 4; i++) pay.push_back($urandom());
        model_pkt(32'd4, 1'b0);
        wr_lvl = 15'd16382;
        @(posedge clk); #1;
        fork
            send_pkt(32'd4, 1'b0, 0);
            begin
                repeat (3) @(posedge clk);
                ok = 1'b1;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    if (src_if.s_ready !== 1'b0 || enq_req !== 1'b0) ok = 1'b0;
                end
                chk("hold_no_ready_no_enq", 64'(ok), 64'(1));
                @(posedge clk); #1;
                wr_lvl = 15'd16380;
                k = 0;
                for (int i = 1; i <= 10 && k == 0; i++) begin
                    @(negedge clk);
                    if (enq_req) k = i;
                end
                chk("release_latency_ok", 64'(k >= 1 && (k - 1) <= SETTLE + 2), 64'(1));
            end
        join
        repeat (2) @(negedge clk);
        cmp_recs("hold");
        wr_lvl = '0;

        // ---- full pulse mid-stream, then reset mid-packet ----
        pay.delete();
        for (int i = 0; i < 8; i++) pay.push_back($urandom());
        @(posedge clk); #1;
        fork
            send_pkt(32'd8, 1'b0, 0);
            begin
                k = 0;
                while (got.size() < 2 && k < 50) begin @(posedge clk); k++; end
                #1 full = 1'b1;
                ok = 1'b1;
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    if (src_if.s_ready !== 1'b0) ok = 1'b0;
                    @(posedge clk); #1;
                end
                full = 1'b0;
                chk("full_stall_ready", 64'(ok), 64'(1));
                k = 0;
                while (got.size() < 5 && k < 50) begin @(posedge clk); k++; end
                #1;
                rst   = 1'b1;
                abort = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
            end
        join
        abort = 1'b0;
        src_if.s_valid = 1'b0;
        src_if.s_last  = 1'b0;
        @(negedge clk);
        chk("rst1_strobes", 64'({enq_req, in_sop, in_eop, pck_len_valid}), 64'(0));
        chk("rst1_data", 64'(wr_data_i), 64'(0));
        chk("rst1_len", 64'(pck_len_i), 64'(0));
        chk_cnts("rst1", 0, 0, 0);
        chk("rst1_s_ready", 64'(src_if.s_ready), 64'(1));
        chk("full_seq_nenq", 64'(got.size()), 64'(5));
        for (int i = 0; i < 5 && i < got.size(); i++)
            chk($sformatf("full_seq_word%0d", i), 64'(got[i]),
                64'(rec_t'{pay[i], (i == 0), 1'b0, (i == 0), 12'd8}));
        got.delete();

        // First word after reset is a header again.
        m_pkt = 0; m_drop = 0; m_err = 0;
        pay.delete();
        pay.push_back(32'h1111_2222);
        pay.push_back(32'h3333_4444);
        model_pkt(32'd2, 1'b0);
        @(posedge clk); #1;
        send_pkt(32'd2, 1'b0, 0);
        repeat (2) @(negedge clk);
        cmp_recs("post_rst");
        chk_cnts("post_rst", m_pkt, m_drop, m_err);

        // ---- randomized packets against the reference model ----
        @(posedge clk); #1;
        rnd_full = 1'b1;
        for (int p = 0; p < 40; p++) begin
            k  = $urandom_range(99);
            hl = 1'b0;
            if (k < 8)       len = 0;
            else if (k < 16) len = $urandom_range(4095, MAX_LEN + 1);
            else             len = $urandom_range(12, 1);
            if ($urandom_range(99) < 6) begin
                hl   = 1'b1;
                npay = 0;
            end else if (len == 0 || len > MAX_LEN) begin
                npay = $urandom_range(3, 1);
            end else begin
                npay = len - 2 + int'($urandom_range(4, 0));
                if (npay < 1) npay = 1;
            end
            hdr       = $urandom();
            hdr[11:0] = 12'(len);
            if (len >= 1 && len <= MAX_LEN)
                wr_lvl = ($urandom_range(3) == 0) ? 15'(FIFO_DEPTH - len)
                                                  : 15'($urandom_range(FIFO_DEPTH - len, 0));
            else
                wr_lvl = 15'($urandom_range(32767, 0));
            pay.delete();
            for (int i = 0; i < npay; i++) pay.push_back($urandom());
            model_pkt(hdr, hl);
            send_pkt(hdr, hl, 20);
            repeat (2) @(negedge clk);
            cmp_recs($sformatf("rnd%0d", p));
            @(posedge clk); #1;
        end
        rnd_full = 1'b0;
        @(posedge clk); #2;
        full = 1'b0;
        chk_cnts("rnd_total", m_pkt, m_drop, m_err);
        chk("no_enq_after_full", 64'(viol), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pkt_proc_ingress_framer.md
# pkt_proc_ingress_framer

Upstream ingress stage for the packet processor. Accepts a header-prefixed word stream from the line side, strips the header, checks the declared length against space left in the packet memory, and drives the processor's enqueue port: `enq_req`, `in_sop`, `in_eop`, `wr_data_i`, `pck_len_valid`, `pck_len_i`. The processor therefore never sees an enqueue it must drop for lack of space. Malformed packets are consumed and discarded here, and counted.

## Interface
- `FIFO_DEPTH`, default 16384: packet memory capacity in 32-bit words; matches the range of `pck_proc_wr_lvl`.
- `MAX_LEN`, default 4095: largest legal payload length in words.
- `SETTLE`, default 2: minimum number of idle cycles after the last `enq_req` before `pck_proc_wr_lvl` is trusted.
- `pck_proc_int_mem_fsm_clk` in 1: the single clock; everything is on its posedge.
- `pck_proc_int_mem_fsm_rst` in 1: synchronous, active-high reset.
- `s_valid` in 1: source word valid.
- `s_ready` out 1: block accepts the word this cycle.
- `s_data` in 32: source word. The first word of each packet is the header; `[11:0]` is the payload length in words.
- `s_last` in 1: last source word of the packet.
- `pck_proc_wr_lvl` in 15: current fill level of the processor memory.
- `pck_proc_full` in 1: processor full.
- `enq_req`, `in_sop`, `in_eop` out 1 each: processor enqueue strobes.
- `wr_data_i` out 32: enqueue data.
- `pck_len_valid` out 1, `pck_len_i` out 12: packet length to the processor.
- `ingress_pkt_cnt`, `ingress_drop_cnt`, `ingress_err_cnt` out 16 each: saturating counters.

## Operation
- FSM states: IDLE, CHECK, STREAM, DISCARD. Reset state is IDLE. All outputs reset to 0.
- **IDLE**
  - `s_ready`=1.
  - On header accept, latch `len=s_data[11:0]`.
  - If `len==0`, or `len>MAX_LEN`, or `s_last` is set on the header: go to DISCARD and increment drop. Exception: a header carrying `s_last` is dropped in place and the FSM stays in IDLE.
  - Otherwise go to CHECK.
- **CHECK**
  - `s_ready`=0.
  - Wait until the idle counter since the last `enq_req` reaches at least SETTLE.
  - Then compare `pck_proc_wr_lvl + len <= FIFO_DEPTH`, using 16-bit arithmetic with no wrap. If true, go to STREAM. If false, stay in CHECK and re-evaluate every cycle; there is no timeout.
- **STREAM**
  - `s_ready = ~pck_proc_full`.
  - Each accepted word is registered into `wr_data_i` with `enq_req`=1.
  - First payload word: `in_sop`=1, `pck_len_valid`=1, `pck_len_i=len`.
  - A word counter `cnt` (12 bits) runs from 1 to `len`.
  - Word `cnt==len` with `s_last`: `in_eop`=1, increment pkt, go to IDLE.
  - Word `cnt==len` without `s_last`: `in_eop`=1 on that word, increment pkt and err, go to DISCARD to drain the surplus.
  - `s_last` with `cnt<len` (short packet): `in_eop`=1 on that word, increment pkt and err, go to IDLE. No padding is inserted.
- **DISCARD**
  - `s_ready`=1.
  - Words are consumed without `enq_req`.
  - On `s_last`, go to IDLE.
- A single-word packet (`len==1`) asserts `in_sop` and `in_eop` on the same enqueue.
- Counters saturate at 0xFFFF and are cleared only by reset.

## Timing
- `s_ready` is combinational from the state and `pck_proc_full`. All other outputs are registered.
- Latency: a word accepted at edge N appears on `wr_data_i`/`enq_req` for exactly cycle N+1, then returns low unless another word was accepted.
- Header to first `enq_req`: at least 1 (IDLE→CHECK) + SETTLE + 1 (CHECK→STREAM) + 1 (output register) cycles.
- `pck_proc_full` rising in STREAM stalls the source the same cycle; no enqueue is issued while it is high.
- `pck_len_valid`/`pck_len_i` are valid only in the `in_sop` cycle; `pck_len_i` holds its value otherwise.
- Reset mid-packet aborts the packet:
  - All enqueue strobes deassert on the next edge.
  - The remainder of the source packet is not discarded: the first word after reset is treated as a header. The source is reset together with this block.

## Structure
- Package `pkt_proc_ingress_pkg`:
  - FSM enum `ingress_state_e`.
  - `LEN_W=12`, `DATA_W=32`, `LVL_W=15`.
  - Header field positions.
- A single sub-module `pkt_proc_sat_cnt` (16-bit saturating counter with increment enable), instantiated three times.
- Everything else stays in the top module.

## Test plan
- Header `len=3`, 3 payload words with `s_last` on the third, `wr_lvl=0`:
  - Exactly 3 `enq_req`.
  - `in_sop`+`pck_len_valid`+`pck_len_i=3` on the first, `in_eop` on the third.
  - `pkt_cnt=1`.
- `wr_lvl=16382`, header `len=4`:
  - Block holds in CHECK with `s_ready`=0.
  - Lower `wr_lvl` to 16380; first `enq_req` follows SETTLE+2 cycles later.
- Header `len=0`, then header `len=5000`, each followed by 2 words:
  - No `enq_req`.
  - `drop_cnt=2`; all words consumed.
- Header `len=4`, `s_last` on payload word 2:
  - 2 enqueues, `in_eop` on the second.
  - `err_cnt=1`.
- Header `len=2`, 4 payload words:
  - 2 enqueues, `in_eop` on the second.
  - Surplus 2 words consumed.
  - `err_cnt=1`.
- `pck_proc_full` pulsed for 3 cycles mid-STREAM, then reset asserted mid-packet:
  - `s_ready`=0 and no enqueue during the pulse; the data sequence is intact.
  - After reset, all outputs are 0 and the FSM is in IDLE.
